// File: rtl/nibble_scan_ctrl.sv
// nibble_scan_ctrl
// Feeds a 4-stage x 4-bit nibble shift register from two req/ack
// requesters. The granted word is streamed MSB nibble first, one nibble
// per clock. The register is enabled once per 4-cycle frame, in the cycle
// after the last nibble, and the same word keeps refreshing until a new
// grant replaces it.
//
// Optional build macro NIBBLE_SCAN_FIXED_PRIO_EN: when defined, req0
// always wins over req1 and last_gnt has no effect. When it is not
// defined, requesters are served round-robin.
//
//  state  | meaning
//  -------+------------------------------------------------------------
//  S_IDLE | blanked; sr_data/sr_ena low; any request is granted at once
//  S_RUN  | streaming cur_word; phase 0..3; re-arbitrate at phase 3
module nibble_scan_ctrl #(
    parameter int WORD_W = 16,
    parameter int NIB_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic [WORD_W-1:0] word0,
    input  logic              req1,
    input  logic [WORD_W-1:0] word1,
    input  logic              disp_en,
    input  logic              clr,
    output logic              ack0,
    output logic              ack1,
    output logic [NIB_W-1:0]  sr_data,
    output logic              sr_ena,
    output logic              busy,
    output logic [1:0]        phase
);

    localparam int NSTAGE = WORD_W / NIB_W;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          phase_d;
    logic                primed_q, primed_d;
    logic [WORD_W-1:0]   cur_word_q, cur_word_d;
    logic                last_gnt_q, last_gnt_d;
    logic                ack0_d, ack1_d;
    logic [NIB_W-1:0]    sr_data_d;
    logic                sr_ena_d;
    logic                busy_d;
    logic                any_req;
    logic                gnt_sel;
    logic                do_grant;
    logic [WORD_W-1:0]   gnt_word;

    // Next-state, arbitration and next-output computation. All outputs are
    // derived from the next state so they can be registered directly.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase;
        primed_d   = primed_q;
        cur_word_d = cur_word_q;
        last_gnt_d = last_gnt_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        do_grant   = 1'b0;
        any_req    = req0 | req1;

`ifdef NIBBLE_SCAN_FIXED_PRIO_EN
        gnt_sel = ~req0;
`else
        // On a tie the requester that was not served last time wins.
        if (req0 && req1) begin
            gnt_sel = ~last_gnt_q;
        end else begin
            gnt_sel = req1;
        end
`endif
        gnt_word = gnt_sel ? word1 : word0;

        if (clr) begin
            state_d  = S_IDLE;
            phase_d  = 2'd0;
            primed_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (any_req) begin
                        state_d  = S_RUN;
                        phase_d  = 2'd0;
                        primed_d = 1'b0;
                        do_grant = 1'b1;
                    end
                end
                S_RUN: begin
                    phase_d = phase + 2'd1;
                    if (phase == 2'd3) begin
                        // The frame just completed is strobed even when a
                        // new word is granted on this same edge.
                        primed_d = 1'b1;
                        do_grant = any_req;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        if (do_grant) begin
            cur_word_d = gnt_word;
            last_gnt_d = gnt_sel;
            ack0_d     = ~gnt_sel;
            ack1_d     = gnt_sel;
        end

        if (state_d == S_RUN) begin
            sr_data_d = NIB_W'(cur_word_d >> (NIB_W * (NSTAGE - 1 - int'(phase_d))));
        end else begin
            sr_data_d = '0;
        end
        sr_ena_d = (state_d == S_RUN) && (phase_d == 2'd0) && primed_d && disp_en;
        busy_d   = (state_d == S_RUN);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            phase      <= 2'd0;
            primed_q   <= 1'b0;
            cur_word_q <= '0;
            last_gnt_q <= 1'b1;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            sr_data    <= '0;
            sr_ena     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase      <= phase_d;
            primed_q   <= primed_d;
            cur_word_q <= cur_word_d;
            last_gnt_q <= last_gnt_d;
            ack0       <= ack0_d;
            ack1       <= ack1_d;
            sr_data    <= sr_data_d;
            sr_ena     <= sr_ena_d;
            busy       <= busy_d;
        end
    end

endmodule

// File: tb/tb_nibble_scan_ctrl.sv
// tb_nibble_scan_ctrl
// Table of vectors for the basic stream, directed sequences for the
// multi-cycle corners, then randomized traffic against a frame-level
// reference model. A shadow 16-bit shift register is fed from sr_data
// so the value presented at each enable pulse can be checked.
module tb_nibble_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1, disp_en, clr;
    logic [15:0] word0, word1;
    logic        ack0, ack1, sr_ena, busy;
    logic [3:0]  sr_data;
    logic [1:0]  phase;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit          m_run;
    int          m_pos;
    int          m_frames;
    logic [15:0] m_word, m_prev;
    bit          m_last;
    bit          m_ack0, m_ack1;
    logic [3:0]  exp_data;
    bit          exp_ena;

    logic [15:0] sr_shadow;
    logic [3:0]  last_data;
    bit          auto_req;
    bit          hold1;

    typedef struct {
        logic       req0;
        logic       disp;
        logic       ack0;
        logic [3:0] data;
        logic       ena;
        logic [1:0] ph;
        logic       busy;
    } vec_t;
    vec_t tbl[13];

    nibble_scan_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req0    (req0),
        .word0   (word0),
        .req1    (req1),
        .word1   (word1),
        .disp_en (disp_en),
        .clr     (clr),
        .ack0    (ack0),
        .ack1    (ack1),
        .sr_data (sr_data),
        .sr_ena  (sr_ena),
        .busy    (busy),
        .phase   (phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp_v);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_pos = 0; m_frames = 0;
        m_word = '0; m_prev = '0; m_last = 1;
        m_ack0 = 0; m_ack1 = 0;
        exp_data = '0; exp_ena = 0;
        sr_shadow = '0; last_data = '0;
    endtask

    // Model one clock edge from the frame-level rules, using the inputs
    // that are stable at that edge.
    task automatic model_edge();
        bit any, sel;
        any = req0 | req1;
`ifdef NIBBLE_SCAN_FIXED_PRIO_EN
        sel = !req0;
`else
        sel = (req0 && req1) ? !m_last : req1;
`endif
        m_ack0 = 0; m_ack1 = 0;
        if (clr) begin
            m_run = 0; m_pos = 0; m_frames = 0;
        end else if (!m_run) begin
            if (any) begin
                m_run = 1; m_pos = 0; m_frames = 0;
                m_word = sel ? word1 : word0;
                m_last = sel; m_ack0 = !sel; m_ack1 = sel;
            end
        end else if (m_pos == 3) begin
            m_pos = 0;
            m_frames++;
            m_prev = m_word;
            if (any) begin
                m_word = sel ? word1 : word0;
                m_last = sel; m_ack0 = !sel; m_ack1 = sel;
            end
        end else begin
            m_pos++;
        end
        exp_data = m_run ? 4'((m_word >> (4 * (3 - m_pos))) & 16'hF) : 4'h0;
        exp_ena  = m_run && (m_pos == 0) && (m_frames > 0) && disp_en;
    endtask

    task automatic step();
        @(posedge clk);
        sr_shadow = {sr_shadow[11:0], last_data};
        model_edge();
        #1;
        chk("ack0", 16'(ack0), 16'(m_ack0));
        chk("ack1", 16'(ack1), 16'(m_ack1));
        chk("sr_data", 16'(sr_data), 16'(exp_data));
        chk("sr_ena", 16'(sr_ena), 16'(exp_ena));
        chk("busy", 16'(busy), 16'(m_run));
        chk("phase", 16'(phase), 16'(m_pos));
        if (exp_ena) chk("ind", sr_shadow, m_prev);
        last_data = sr_data;
        if (m_ack0) req0 = 0;
        if (m_ack1 && !hold1) req1 = 0;
        if (auto_req) begin
            if (!req0 && $urandom_range(0, 3) == 0) begin req0 = 1; word0 = 16'($urandom); end
            if (!req1 && $urandom_range(0, 3) == 0) begin req1 = 1; word1 = 16'($urandom); end
            disp_en = ($urandom_range(0, 7) != 0);
            clr     = ($urandom_range(0, 39) == 0);
        end
    endtask

    task automatic do_reset();
        rst_n = 0; req0 = 0; req1 = 0; clr = 0; disp_en = 1;
        word0 = '0; word1 = '0; auto_req = 0; hold1 = 0;
        #1;
        chk("rst_outs", {ack0, ack1, sr_data, sr_ena, busy, phase}, 16'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1;
        model_reset();
    endtask

    initial begin
        logic [15:0] strobes[$];
        bit          have_prev, prev_g, g;

        for (int n = 0; n < 13; n++) begin
            tbl[n].req0 = (n == 0);
            tbl[n].disp = 1'b1;
            tbl[n].ack0 = (n == 0);
            tbl[n].data = 4'((n % 4) + 1);
            tbl[n].ena  = (n % 4 == 0) && (n > 0);
            tbl[n].ph   = 2'(n % 4);
            tbl[n].busy = 1'b1;
        end

        // 1: table-driven stream of 0x1234
        do_reset();
        chk("reset_busy", 16'(busy), 16'h0);
        word0 = 16'h1234;
        for (int n = 0; n < 13; n++) begin
            req0 = tbl[n].req0;
            disp_en = tbl[n].disp;
            step();
            chk("t_ack0", 16'(ack0), 16'(tbl[n].ack0));
            chk("t_data", 16'(sr_data), 16'(tbl[n].data));
            chk("t_ena", 16'(sr_ena), 16'(tbl[n].ena));
            chk("t_phase", 16'(phase), 16'(tbl[n].ph));
            chk("t_busy", 16'(busy), 16'(tbl[n].busy));
            if (tbl[n].ena) chk("t_ind", sr_shadow, 16'h1234);
        end

        // 2: simultaneous requests; req1 is served at the first phase-3
        // edge, so only the first strobe shows 0xAAAA
        do_reset();
        req0 = 1; word0 = 16'hAAAA; req1 = 1; word1 = 16'h5555;
        step();
        chk("tie_ack0", 16'(ack0), 16'h1);
        chk("tie_ack1", 16'(ack1), 16'h0);
        for (int n = 1; n < 16; n++) begin
            step();
            if (sr_ena) strobes.push_back(sr_shadow);
        end
        chk("tie_nstrobe", 16'(strobes.size()), 16'd3);
        if (strobes.size() == 3) begin
            chk("tie_s0", strobes[0], 16'hAAAA);
            chk("tie_s1", strobes[1], 16'h5555);
            chk("tie_s2", strobes[2], 16'h5555);
        end

        // 3: req1 held, req0 re-raised each frame -> grants alternate
        do_reset();
        hold1 = 1; req1 = 1; word1 = 16'h0F0F; req0 = 1; word0 = 16'hF0F0;
        have_prev = 0; prev_g = 0;
        for (int n = 0; n < 32; n++) begin
            step();
            if (ack0 || ack1) begin
                g = ack1;
                if (have_prev) chk("alt", 16'(g), 16'(!prev_g));
                else chk("alt_first", 16'(g), 16'h0);
                have_prev = 1; prev_g = g;
            end
            if (!req0 && m_pos == 1) req0 = 1;
        end
        hold1 = 0;

        // 4: disp_en low for frames 2-3 masks only the enable
        do_reset();
        req0 = 1; word0 = 16'hBEEF;
        for (int n = 0; n < 20; n++) begin
            disp_en = !(n >= 4 && n < 12);
            step();
            chk("de_phase", 16'(phase), 16'(n % 4));
            chk("de_ena", 16'(sr_ena), 16'((n % 4 == 0) && n >= 12));
        end
        disp_en = 1;

        // 5: clr at phase 2 with req1 pending
        do_reset();
        req0 = 1; word0 = 16'h1357;
        for (int n = 0; n < 7; n++) begin
            if (n == 5) begin req1 = 1; word1 = 16'h2468; end
            step();
        end
        chk("clr_pre_phase", 16'(phase), 16'd2);
        clr = 1;
        step();
        chk("clr_busy", 16'(busy), 16'h0);
        chk("clr_data", 16'(sr_data), 16'h0);
        chk("clr_ena", 16'(sr_ena), 16'h0);
        chk("clr_ack1", 16'(ack1), 16'h0);
        clr = 0;
        step();
        chk("post_clr_ack1", 16'(ack1), 16'h1);
        chk("post_clr_data", 16'(sr_data), 16'h2);

        // 6: reset pulse mid-frame at phase 1
        do_reset();
        req0 = 1; word0 = 16'h9ABC;
        step();
        step();
        chk("mid_phase", 16'(phase), 16'd1);
        rst_n = 0;
        #1;
        chk("mid_rst_outs", {ack0, ack1, sr_data, sr_ena, busy, phase}, 16'h0);
        @(posedge clk);
        #1;
        rst_n = 1;
        model_reset();
        req0 = 1; word0 = 16'h4321; req1 = 1; word1 = 16'h8765;
        step();
        chk("rst_first_ack0", 16'(ack0), 16'h1);
        chk("rst_first_ack1", 16'(ack1), 16'h0);

        // 7: randomized traffic against the model
        do_reset();
        auto_req = 1;
        for (int n = 0; n < 3000; n++) step();
        auto_req = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
